// File: rtl/flash_fetch_ctrl.sv
// Instruction-fetch sequencer: reads a 16-bit instruction as two bytes (high first)
// from a byte-wide parallel flash, with WAIT_CYCLES extra cycles per byte read.
module flash_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [7:0]            mem_data,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic                  mem_rd_n,
  output logic [15:0]           flash_data,
  output logic                  flash_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, VALID} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] held_addr;
  logic [7:0]            hi_byte;
  logic [3:0]            wcnt;
  logic                  valid;

  logic start_fetch;
  logic abort;
  logic byte_done;

  assign start_fetch = fetch_en && ((state == IDLE) || (pc != held_addr));
  assign abort       = ((state == RD_HI) || (state == RD_LO)) && (pc != fetch_addr);
  assign byte_done   = (wcnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, VALID: if (start_fetch) state_nxt = RD_HI;
      RD_HI: begin
        if (abort)          state_nxt = RD_HI;
        else if (byte_done) state_nxt = RD_LO;
      end
      RD_LO: begin
        if (abort)          state_nxt = RD_HI;
        else if (byte_done) state_nxt = VALID;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == RD_HI) || (state == RD_LO);
    flash_ready = valid && (held_addr == pc) && (state == VALID);
  end

  // Abort outranks byte capture so a stale byte never lands in hi_byte/flash_data.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      fetch_addr <= '0;
      held_addr  <= '0;
      hi_byte    <= '0;
      wcnt       <= '0;
      valid      <= 1'b0;
      mem_addr   <= '0;
      mem_rd_n   <= 1'b1;
      flash_data <= '0;
    end else begin
      case (state)
        IDLE, VALID: begin
          if (start_fetch) begin
            fetch_addr <= pc;
            mem_addr   <= {pc, 1'b0};
            mem_rd_n   <= 1'b0;
            wcnt       <= '0;
          end else begin
            mem_rd_n   <= 1'b1;
          end
        end
        RD_HI, RD_LO: begin
          if (abort) begin
            fetch_addr <= pc;
            mem_addr   <= {pc, 1'b0};
            mem_rd_n   <= 1'b0;
            wcnt       <= '0;
          end else if (byte_done) begin
            wcnt <= '0;
            if (state == RD_HI) begin
              hi_byte  <= mem_data;
              mem_addr <= {fetch_addr, 1'b1};
            end else begin
              flash_data <= {hi_byte, mem_data};
              held_addr  <= fetch_addr;
              valid      <= 1'b1;
              mem_rd_n   <= 1'b1;
            end
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        default: mem_rd_n <= 1'b1;
      endcase
    end
  end

endmodule
